// File: rtl/ptltx_pkg.sv
// Shared types and default constants for the multi-lane PTL transmitter array.
package ptltx_pkg;

    typedef enum logic [1:0] {
        READY = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } lane_state_t;

    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_DELAY_CYC   = 22;
    localparam int DEF_CT_CYC      = 35;
    localparam int DEF_STARTUP_CYC = 40;
    localparam int DEF_CNT_W       = 16;

    // Smallest width able to hold the value v (at least one bit).
    function automatic int width_for(input int v);
        return (v > 0) ? $clog2(v + 1) : 1;
    endfunction

endpackage

// File: rtl/ptltx_lane.sv
// One transmitter lane: accepts gated SFQ events, enforces the critical-timing
// window, replays accepted toggles after a fixed delay and counts accepted events.
module ptltx_lane
    import ptltx_pkg::*;
#(
    parameter int DELAY_CYC = DEF_DELAY_CYC,
    parameter int CT_CYC    = DEF_CT_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev,
    input  logic             err_clr,
    output logic             q,
    output logic             err,
    output logic [CNT_W-1:0] tx_cnt
);

    localparam int WIN_W = width_for(CT_CYC - 1);

    lane_state_t          state;
    lane_state_t          next_state;
    logic [WIN_W-1:0]     win_cnt;
    logic [DELAY_CYC-1:0] dl;
    logic                 accept;
    logic                 violate;

    // Decide the lane's next state and whether this cycle's event is accepted or a violation.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        violate    = 1'b0;
        case (state)
            READY: begin
                if (ev) begin
                    accept = 1'b1;
                    if (CT_CYC > 1) begin
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ev) begin
                    violate    = 1'b1;
                    next_state = FAULT;
                end else if (win_cnt == WIN_W'(1)) begin
                    next_state = READY;
                end
            end
            FAULT: begin
                if (err_clr) begin
                    next_state = READY;
                end
            end
            default: next_state = READY;
        endcase
    end

    // State, window counter, delay line, output level, error flag and pulse counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= READY;
            win_cnt <= '0;
            dl      <= '0;
            q       <= 1'b0;
            err     <= 1'b0;
            tx_cnt  <= '0;
        end else begin
            state <= next_state;

            if (accept) begin
                win_cnt <= WIN_W'(CT_CYC - 1);
            end else if (state == HOLD) begin
                win_cnt <= win_cnt - WIN_W'(1);
            end

            if (violate) begin
                dl  <= '0;
                err <= 1'b1;
            end else begin
                dl[0] <= accept;
                for (int j = 1; j < DELAY_CYC; j++) begin
                    dl[j] <= dl[j-1];
                end
                q <= q ^ dl[DELAY_CYC-1];
                if (state == FAULT && err_clr) begin
                    err <= 1'b0;
                end
            end

            if (accept && (tx_cnt != '1)) begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ptltx_array.sv
// Multi-lane PTL transmitter array: shared startup blanking and edge detection,
// with one independent lane per channel.
module ptltx_array
    import ptltx_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int DELAY_CYC   = DEF_DELAY_CYC,
    parameter int CT_CYC      = DEF_CT_CYC,
    parameter int STARTUP_CYC = DEF_STARTUP_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       err_clr,
    output logic [CHANNELS-1:0]       q,
    output logic [CHANNELS-1:0]       err,
    output logic [CHANNELS*CNT_W-1:0] tx_cnt
);

    localparam int SU_W = width_for(STARTUP_CYC);

    logic [SU_W-1:0]     startup_cnt;
    logic [CHANNELS-1:0] a_prev;
    logic [CHANNELS-1:0] ev;

    assign ev = (a ^ a_prev) & {CHANNELS{startup_cnt == '0}};

    // Previous input levels for edge detection and the post-reset blanking counter.
    always_ff @(posedge clk) begin
        a_prev <= a;
        if (rst) begin
            startup_cnt <= SU_W'(STARTUP_CYC);
        end else if (startup_cnt != '0) begin
            startup_cnt <= startup_cnt - SU_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        ptltx_lane #(
            .DELAY_CYC(DELAY_CYC),
            .CT_CYC   (CT_CYC),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .ev     (ev[i]),
            .err_clr(err_clr[i]),
            .q      (q[i]),
            .err    (err[i]),
            .tx_cnt (tx_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_ptltx_array.sv
// Scoreboard bench for ptltx_array: a timeline-based reference model predicts the
// outputs after every edge; a monitor compares them one cycle at a time.
module tb_ptltx_array;
    import ptltx_pkg::*;

    localparam int CH   = 4;
    localparam int D    = 22;
    localparam int CT   = 35;
    localparam int SU   = 40;
    localparam int CW   = 2;
    localparam int MAXN = 8192;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    a;
    logic [CH-1:0]    err_clr;
    logic [CH-1:0]    q;
    logic [CH-1:0]    err;
    logic [CH*CW-1:0] tx_cnt;

    int tests = 0;
    int fails = 0;

    ptltx_array #(
        .CHANNELS   (CH),
        .DELAY_CYC  (D),
        .CT_CYC     (CT),
        .STARTUP_CYC(SU),
        .CNT_W      (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .err_clr(err_clr),
        .q      (q),
        .err    (err),
        .tx_cnt (tx_cnt)
    );

    // Free-running time-step clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0]    q;
        logic [CH-1:0]    err;
        logic [CH*CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: absolute edge numbers, a toggle timeline and last-accept times.
    int            n = 0;
    int            reset_edge = 0;
    int            rel = 0;
    int            mon_edge = 0;
    logic [CH-1:0] a_cur = '0;
    logic [CH-1:0] m_prev = '0;
    logic [CH-1:0] m_q = '0;
    logic [CH-1:0] m_err = '0;
    bit            m_fault[CH];
    bit            m_has_acc[CH];
    int            m_last_acc[CH];
    int            m_cnt[CH];
    bit            sched[CH][MAXN];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s (edge %0d, rel %0d): got %0h expected %0h", name, n, rel, act, expv);
        end
    endtask

    task automatic modelEdge(input logic [CH-1:0] a_v, input logic [CH-1:0] clr_v, input logic rst_v);
        exp_t e;
        bit   ev;
        bit   live;
        bit   viol;
        if (rst_v) begin
            for (int i = 0; i < CH; i++) begin
                m_fault[i]   = 1'b0;
                m_has_acc[i] = 1'b0;
                m_cnt[i]     = 0;
                for (int t = n; t <= n + D; t++) sched[i][t] = 1'b0;
            end
            m_q        = '0;
            m_err      = '0;
            m_prev     = a_v;
            reset_edge = n;
        end else begin
            for (int i = 0; i < CH; i++) begin
                ev   = (a_v[i] != m_prev[i]);
                live = (n - reset_edge) > SU;
                viol = 1'b0;
                if (m_fault[i]) begin
                    if (clr_v[i]) begin
                        m_fault[i] = 1'b0;
                        m_err[i]   = 1'b0;
                    end
                end else if (ev && live) begin
                    if (m_has_acc[i] && (n - m_last_acc[i] < CT)) begin
                        viol         = 1'b1;
                        m_fault[i]   = 1'b1;
                        m_err[i]     = 1'b1;
                        m_has_acc[i] = 1'b0;
                        for (int t = n; t <= n + D; t++) sched[i][t] = 1'b0;
                    end else begin
                        m_has_acc[i]  = 1'b1;
                        m_last_acc[i] = n;
                        sched[i][n+D] = 1'b1;
                        if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
                    end
                end
                if (!viol && sched[i][n]) m_q[i] = ~m_q[i];
                m_prev[i] = a_v[i];
            end
        end
        e.q   = m_q;
        e.err = m_err;
        for (int i = 0; i < CH; i++) e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
        exp_q.push_back(e);
        n++;
    endtask

    task automatic applyStimulus(input logic [CH-1:0] a_v, input logic [CH-1:0] clr_v, input logic rst_v);
        a       = a_v;
        err_clr = clr_v;
        rst     = rst_v;
        modelEdge(a_v, clr_v, rst_v);
        rel = rst_v ? 0 : rel + 1;
        @(posedge clk);
        #2;
    endtask

    task automatic idleUntil(input int t);
        while (rel < t - 1) applyStimulus(a_cur, '0, 1'b0);
    endtask

    task automatic eventAt(input int t, input logic [CH-1:0] mask, input logic [CH-1:0] clr);
        idleUntil(t);
        a_cur = a_cur ^ mask;
        applyStimulus(a_cur, clr, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(a_cur, '0, 1'b1);
    endtask

    // Monitor: after every edge, pop the predicted outputs and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            mon_edge++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput($sformatf("q@%0d", mon_edge), 32'(q), 32'(e.q));
                checkOutput($sformatf("err@%0d", mon_edge), 32'(err), 32'(e.err));
                checkOutput($sformatf("tx_cnt@%0d", mon_edge), 32'(tx_cnt), 32'(e.cnt));
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [CH-1:0] mask;
        logic [CH-1:0] clr;

        doReset();
        checkOutput("reset_q", 32'(q), 32'(0));
        checkOutput("reset_err", 32'(err), 32'(0));
        checkOutput("reset_cnt", 32'(tx_cnt), 32'(0));

        // Startup blanking on lane 1, latency on lane 0, boundary-legal pair on lane 2.
        eventAt(10, 4'b0010, 4'b0000);
        eventAt(50, 4'b0001, 4'b0000);
        idleUntil(72);
        checkOutput("lat_q0_before", 32'(q[0]), 32'(0));
        applyStimulus(a_cur, '0, 1'b0);
        checkOutput("lat_q0_at72", 32'(q[0]), 32'(1));
        eventAt(100, 4'b0100, 4'b0000);
        eventAt(135, 4'b0100, 4'b0000);
        idleUntil(181);
        checkOutput("p1_q", 32'(q), 32'(4'b0001));
        checkOutput("p1_err", 32'(err), 32'(0));
        checkOutput("p1_cnt1", 32'(tx_cnt[1*CW +: CW]), 32'(0));
        checkOutput("p1_cnt2", 32'(tx_cnt[2*CW +: CW]), 32'(2));

        // Violations, flush of a pending toggle, fault lock-out, clear and same-cycle clear.
        doReset();
        eventAt(100, 4'b1110, 4'b0000);
        eventAt(110, 4'b1010, 4'b1000);
        eventAt(134, 4'b0100, 4'b0000);
        eventAt(200, 4'b0100, 4'b0000);
        checkOutput("p2_err_locked", 32'(err), 32'(4'b1110));
        idleUntil(210);
        applyStimulus(a_cur, 4'b0100, 1'b0);
        eventAt(220, 4'b0100, 4'b0000);
        idleUntil(261);
        checkOutput("p2_err", 32'(err), 32'(4'b1010));
        checkOutput("p2_q", 32'(q), 32'(0));
        checkOutput("p2_cnt2", 32'(tx_cnt[2*CW +: CW]), 32'(2));

        // Counter saturation on lane 0.
        doReset();
        for (int k = 0; k < 5; k++) eventAt(60 + 40 * k, 4'b0001, 4'b0000);
        idleUntil(261);
        checkOutput("sat_cnt0", 32'(tx_cnt[0 +: CW]), 32'(3));
        checkOutput("sat_q0", 32'(q[0]), 32'(1));

        // Reset while a toggle is pending.
        doReset();
        eventAt(60, 4'b0001, 4'b0000);
        idleUntil(65);
        applyStimulus(a_cur, '0, 1'b1);
        idleUntil(121);
        checkOutput("rst_drop_q", 32'(q), 32'(0));
        checkOutput("rst_drop_cnt", 32'(tx_cnt), 32'(0));

        // Randomized traffic with occasional clears and resets.
        for (int c = 0; c < 2500; c++) begin
            mask = '0;
            clr  = '0;
            for (int i = 0; i < CH; i++) begin
                mask[i] = ($urandom_range(0, 29) == 0);
                clr[i]  = ($urandom_range(0, 14) == 0);
            end
            a_cur = a_cur ^ mask;
            applyStimulus(a_cur, clr, ($urandom_range(0, 699) == 0));
        end

        checkOutput("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
